bin2bcd_8: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3, "double dabble") for the 8-bit product of the 4x4 shift-add multiplier. Sits directly downstream of the multiplier: its `init` is driven by the multiplier's `done` pulse and its `bin` by the multiplier's `pp`. It produces three packed BCD digits (hundreds/tens/ones) for the display stage. It is iterative: one adjust cycle plus one shift cycle per input bit, controlled by a small FSM.

---
 rtl/bin2bcd_8.sv | 122 ++++++++++++
 tb/tb_bin2bcd_8.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_8.sv
// bin2bcd_8: sequential shift-add-3 ("double dabble") converter that turns the
// 8-bit multiplier product into three packed BCD digits (hundreds/tens/ones).
// Each input bit costs one ADJ cycle plus one SHIFT cycle, so a conversion
// takes 16 cycles from the start edge to the one-cycle done pulse.
// Optional feature: define BIN2BCD_LZB_EN to blank leading zeros (written as
// 4'hF) in the hundreds and tens digits when the result register is loaded.
module bin2bcd_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADJ   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  // wr: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary remainder
  logic [19:0] wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  // Add-3 correction applied independently to each BCD nibble; the 4-bit add
  // deliberately drops any carry out of the nibble.
  logic [11:0] adj_digits;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj_digits[gi*4 +: 4] = (wr_q[8 + gi*4 +: 4] >= 4'd5)
                                   ? (wr_q[8 + gi*4 +: 4] + 4'd3)
                                   : wr_q[8 + gi*4 +: 4];
    end
  endgenerate

  // Working register after the left shift performed in SHIFT.
  logic [19:0] wr_shl;
  assign wr_shl = {wr_q[18:0], 1'b0};

  // Value written into the bcd register on the final shift.
  logic [11:0] load_val;
`ifdef BIN2BCD_LZB_EN
  logic [3:0] hund_digit;
  logic [3:0] tens_digit;
  assign hund_digit = wr_shl[19:16];
  assign tens_digit = wr_shl[15:12];
  assign load_val = {
    (hund_digit == 4'd0) ? 4'hF : hund_digit,
    ((hund_digit == 4'd0) && (tens_digit == 4'd0)) ? 4'hF : tens_digit,
    wr_shl[11:8]
  };
`else
  assign load_val = wr_shl[19:8];
`endif

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          wr_d    = {12'h000, bin};
          cnt_d   = 4'd8;
          state_d = ADJ;
        end
      end
      ADJ: begin
        wr_d    = {adj_digits, wr_q[7:0]};
        state_d = SHIFT;
      end
      SHIFT: begin
        wr_d  = wr_shl;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          bcd_d   = load_val;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ADJ;
        end
      end
      DONE: begin
        // done_q is high during this state; always return to IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any conversion in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 20'h00000;
      cnt_q   <= 4'd0;
      bcd_q   <= 12'h000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_8.sv
// Testbench for bin2bcd_8: scoreboard of expected BCD results pushed at each
// start and popped when done is observed. Inputs change on the falling edge;
// outputs are sampled on the falling edge.
module tb_bin2bcd_8;

  logic        clk;
  logic        rst;
  logic        init;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        done;

  int n_checks;
  int n_fail;
  logic [11:0] exp_q[$];

  bin2bcd_8 dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .bin  (bin),
    .bcd  (bcd),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference for an 8-bit value, with optional blanking.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef BIN2BCD_LZB_EN
    if (h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
`endif
    return {h, t, o};
  endfunction

  // Called at a falling edge with the DUT idle: one-cycle init pulse.
  // Returns at the falling edge right after the start edge (E0).
  task automatic start_conv(input int v);
    init = 1'b1;
    bin  = 8'(v);
    exp_q.push_back(ref_bcd(v));
    @(negedge clk);
    init = 1'b0;
  endtask

  // Waits (bounded) until done is seen high at a falling edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    init = 1'b0;
    bin  = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bcd !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_bcd: got %h expected 000", bcd);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    $display("reset: bcd=%h done=%b", bcd, done);
  endtask

  task automatic test_basic;
    int vals[4] = '{0, 255, 99, 100};
    int cyc;
    logic [11:0] e;
    foreach (vals[k]) begin
      start_conv(vals[k]);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 16) begin
        n_fail++;
        $display("FAIL basic_latency bin=%0d: got %0d cycles expected 16", vals[k], cyc);
      end
      n_checks++;
      if (bcd !== e) begin
        n_fail++;
        $display("FAIL basic_bcd bin=%0d: got %h expected %h", vals[k], bcd, e);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_done_width bin=%0d: done still %b one cycle later", vals[k], done);
      end
      $display("basic: bin=%0d bcd=%h expected=%h latency=%0d", vals[k], bcd, e, cyc);
    end
  endtask

  task automatic test_sweep;
    int cyc;
    int bad;
    logic [11:0] e;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      start_conv(v);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc != 16 || bcd !== e) begin
        n_fail++;
        bad++;
        $display("FAIL sweep bin=%0d: got %h after %0d cycles expected %h after 16", v, bcd, cyc, e);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        bad++;
        $display("FAIL sweep_done_width bin=%0d: done still %b", v, done);
      end
    end
    $display("sweep: 256 conversions, %0d mismatches", bad);
  endtask

  task automatic test_ignore_init;
    int cyc;
    int extra;
    logic [11:0] e;
    start_conv(42);                // now at falling edge after E0
    repeat (4) @(negedge clk);     // falling edge after E4
    init = 1'b1;                   // sampled at E5, must be ignored
    bin  = 8'd200;
    @(negedge clk);
    init = 1'b0;
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (bcd !== e) begin
      n_fail++;
      $display("FAIL ignore_bcd: got %h expected %h", bcd, e);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignore_extra_done: got %0d extra pulses expected 0", extra);
    end
    $display("ignore_init: bcd=%h expected=%h extra_done=%0d", bcd, e, extra);
  endtask

  task automatic test_reset_abort;
    int cyc;
    int seen;
    logic [11:0] e;
    start_conv(200);               // falling edge after E0
    repeat (8) @(negedge clk);     // falling edge after E8
    rst = 1'b1;                    // sampled at E9
    @(negedge clk);
    n_checks++;
    if (bcd !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_bcd: got %h expected 000", bcd);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got %b expected 0", done);
    end
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_late_done: got %0d pulses expected 0", seen);
    end
    start_conv(200);
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc != 16 || bcd !== e) begin
      n_fail++;
      $display("FAIL abort_restart: got %h after %0d cycles expected %h after 16", bcd, cyc, e);
    end
    @(negedge clk);
    $display("reset_abort: restart bcd=%h expected=%h", bcd, e);
  endtask

  task automatic test_back_to_back;
    int cyc;
    int gap;
    int extra;
    logic [11:0] e;
    init = 1'b1;
    bin  = 8'd42;
    exp_q.push_back(ref_bcd(42));
    @(negedge clk);                // after E0
    repeat (3) @(negedge clk);
    bin = 8'd7;                    // next start (E18) samples 7
    exp_q.push_back(ref_bcd(7));
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (bcd !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", bcd, e);
    end
    $display("back_to_back: first bcd=%h expected=%h", bcd, e);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (done !== 1'b1 && gap < 40);
    init = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (gap != 18) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles expected 18", gap);
    end
    n_checks++;
    if (bcd !== e) begin
      n_fail++;
      $display("FAIL b2b_second: got %h expected %h", bcd, e);
    end
    $display("back_to_back: second bcd=%h expected=%h period=%0d", bcd, e, gap);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_tail: got %0d extra pulses expected 0", extra);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    init = 1'b0;
    bin  = 8'd0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_sweep;
    test_ignore_init;
    test_reset_abort;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
